// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial line between the RAM-dump stage and the UART transmitter.
// The dump stage is the master; the transmitter is the slave.
interface uart_tx_serializer_if;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD_busy;
    logic       TxD;

    modport master (
        output TxD_start,
        output TxD_data,
        input  TxD_busy,
        input  TxD
    );

    modport slave (
        input  TxD_start,
        input  TxD_data,
        output TxD_busy,
        output TxD
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stops.
// TxD and TxD_busy are registered; busy covers exactly one whole frame from the accept edge.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_serializer_if.slave  bus
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 1);
    localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bits, bits_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic          txd, txd_n;
    logic          busy, busy_n;

    assign bus.TxD      = txd;
    assign bus.TxD_busy = busy;

    // State and datapath registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            baud  <= '0;
            bits  <= '0;
            shift <= '0;
            par   <= 1'b0;
            txd   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            baud  <= baud_n;
            bits  <= bits_n;
            shift <= shift_n;
            par   <= par_n;
            txd   <= txd_n;
            busy  <= busy_n;
        end
    end

    // Next-state and next-output logic; every advance happens when the baud count hits zero.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bits_n  = bits;
        shift_n = shift;
        par_n   = par;
        txd_n   = txd;
        busy_n  = busy;

        if (state != S_IDLE && baud != '0) begin
            baud_n = baud - BW'(1);
        end

        unique case (state)
            S_IDLE: begin
                if (bus.TxD_start) begin
                    state_n = S_START;
                    baud_n  = BAUD_LOAD;
                    bits_n  = '0;
                    shift_n = bus.TxD_data;
                    par_n   = PAR_ODD ? ~^bus.TxD_data : ^bus.TxD_data;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (baud == '0) begin
                    state_n = S_DATA;
                    baud_n  = BAUD_LOAD;
                    bits_n  = '0;
                    txd_n   = shift[0];
                end
            end
            S_DATA: begin
                if (baud == '0) begin
                    baud_n = BAUD_LOAD;
                    if (bits == 3'd7) begin
                        bits_n = '0;
                        if (PAR_EN) begin
                            state_n = S_PARITY;
                            txd_n   = par;
                        end else begin
                            state_n = S_STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bits_n  = bits + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        txd_n   = shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud == '0) begin
                    state_n = S_STOP;
                    baud_n  = BAUD_LOAD;
                    bits_n  = '0;
                    txd_n   = 1'b1;
                end
            end
            S_STOP: begin
                if (baud == '0) begin
                    txd_n = 1'b1;
                    if (bits == STOP_LAST) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        bits_n = bits + 3'd1;
                        baud_n = BAUD_LOAD;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: 8N1, 8E2 and 8O2 instances at 4 clocks per bit.
// A per-cycle waveform model built from the frame format is compared every cycle.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data;

    logic [2:0] txd_v, busy_v, exp_tx_v, exp_busy_v;
    int         mf_a[3];

    int n_assert = 0;
    int n_fail   = 0;

    int         run[3];
    int         idle_run[3];
    int         last_busy[3];
    int         last_gap[3];
    int         dframes[3];
    logic [11:0] cap[3];
    logic [2:0] prev_busy = 3'b000;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PAR = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int STP = (g == 0) ? 1 : 2;

        uart_tx_serializer_if u_bus ();

        assign u_bus.TxD_start = start;
        assign u_bus.TxD_data  = data;
        assign txd_v[g]        = u_bus.TxD;
        assign busy_v[g]       = u_bus.TxD_busy;

        uart_tx_serializer #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR),
            .STOP_BITS   (STP)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (u_bus)
        );

        logic q[$];
        logic exp_tx   = 1'b1;
        logic exp_busy = 1'b0;
        int   mframes  = 0;
        int   ones;

        assign exp_tx_v[g]   = exp_tx;
        assign exp_busy_v[g] = exp_busy;
        assign mf_a[g]       = mframes;

        function automatic void add_bit(input logic b);
            for (int k = 0; k < CPB; k++) q.push_back(b);
        endfunction

        // Expected line: a queue of per-cycle levels for the frame in flight.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end else begin
                if (!exp_busy && start) begin
                    ones = $countones(data);
                    add_bit(1'b0);
                    for (int i = 0; i < 8; i++) add_bit(data[i]);
                    if (PAR == 2) add_bit(ones % 2 == 1);
                    if (PAR == 1) add_bit(ones % 2 == 0);
                    for (int s = 0; s < STP; s++) add_bit(1'b1);
                    mframes++;
                end
                if (q.size() > 0) begin
                    exp_tx   = q.pop_front();
                    exp_busy = 1'b1;
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            assert (txd_v[i] === exp_tx_v[i]) else begin
                n_fail++;
                $error("FAIL txd[%0d] @%0t: got %b expected %b",
                       i, $time, txd_v[i], exp_tx_v[i]);
            end
            n_assert++;
            assert (busy_v[i] === exp_busy_v[i]) else begin
                n_fail++;
                $error("FAIL busy[%0d] @%0t: got %b expected %b",
                       i, $time, busy_v[i], exp_busy_v[i]);
            end
            if (busy_v[i] === 1'b1) begin
                if (prev_busy[i] !== 1'b1) begin
                    run[i]      = 0;
                    last_gap[i] = idle_run[i];
                    dframes[i]++;
                end
                if (run[i] % CPB == CPB / 2 && run[i] / CPB < 12)
                    cap[i][run[i] / CPB] = txd_v[i];
                run[i]++;
                idle_run[i] = 0;
            end else begin
                if (prev_busy[i] === 1'b1) last_busy[i] = run[i];
                idle_run[i]++;
            end
        end
        prev_busy = busy_v;
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        while (busy_v !== 3'b000 && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", {29'd0, busy_v}, 32'd0);
    endtask

    task automatic pulse(input logic [7:0] d);
        data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            run[i] = 0; idle_run[i] = 0; last_busy[i] = 0;
            last_gap[i] = 0; dframes[i] = 0; cap[i] = '0;
        end

        repeat (3) tick();
        chk("reset_txd", {29'd0, txd_v}, 32'd7);
        chk("reset_busy", {29'd0, busy_v}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_txd", {29'd0, txd_v}, 32'd7);

        // 8N1 waveform for 0xA5 and busy lengths for every format
        pulse(8'hA5);
        wait_idle();
        chk("t1_frame_8n1", {22'd0, cap[0][9:0]}, {22'd0, 1'b1, 8'hA5, 1'b0});
        chk("t1_len_8n1", last_busy[0], 40);
        chk("t1_len_8e2", last_busy[1], 48);
        chk("t1_len_8o2", last_busy[2], 48);

        // parity and double stop for 0x07
        pulse(8'h07);
        wait_idle();
        chk("t2_frame_8e2", {20'd0, cap[1]}, {20'd0, 2'b11, 1'b1, 8'h07, 1'b0});
        chk("t2_frame_8o2", {20'd0, cap[2]}, {20'd0, 2'b11, 1'b0, 8'h07, 1'b0});
        chk("t2_len_8e2", last_busy[1], 48);

        // dump-stage handshake: start held 3 cycles, then a second byte
        d0    = dframes[0];
        data  = 8'h01;
        start = 1'b1;
        tick();
        chk("t3_busy_2nd_cycle", {29'd0, busy_v}, 32'd7);
        tick();
        tick();
        start = 1'b0;
        wait_idle();
        data  = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        chk("t3_frames", dframes[0] - d0, 2);
        chk("t3_frame0", {22'd0, cap[0][9:0]}, {22'd0, 1'b1, 8'h00, 1'b0});

        // start held continuously, data incrementing every cycle
        data  = 8'h10;
        start = 1'b1;
        repeat (200) begin
            tick();
            data = data + 8'd1;
        end
        start = 1'b0;
        wait_idle();
        chk("t4_gap_8n1", last_gap[0], 1);
        chk("t4_gap_8e2", last_gap[1], 1);

        // reset in the middle of data bit 3
        pulse(8'hFF);
        repeat (18) tick();
        chk("t5_busy_before", {29'd0, busy_v}, 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_txd", {29'd0, txd_v}, 32'd7);
        chk("t5_rst_busy", {29'd0, busy_v}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse(8'h3C);
        wait_idle();
        chk("t5_frame_8n1", {22'd0, cap[0][9:0]}, {22'd0, 1'b1, 8'h3C, 1'b0});
        chk("t5_frame_8e2", {20'd0, cap[1]}, {20'd0, 2'b11, 1'b0, 8'h3C, 1'b0});
        chk("t5_len_8n1", last_busy[0], 40);

        // start and data changes while busy are ignored
        d0 = dframes[0];
        pulse(8'h5A);
        repeat (10) tick();
        data  = 8'hFF;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        data  = 8'h00;
        wait_idle();
        chk("t6_frame", {22'd0, cap[0][9:0]}, {22'd0, 1'b1, 8'h5A, 1'b0});
        chk("t6_frames", dframes[0] - d0, 1);

        // random requests and bytes
        repeat (400) begin
            start = ($urandom % 6 == 0);
            data  = 8'($urandom);
            tick();
        end
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("frames[%0d]", i), dframes[i], mf_a[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
